// File: rtl/de_isa_def.sv
// de_isa_def: shared ISA definitions for the decode front end.
//   - LEN_* length codes (as reported on inst_len_o)
//   - OP_* native 6-bit opcodes, OP16_* compressed 3-bit opcode codes
//   - len_of / parcels_of: instruction length from the head parcel
//   - canonicalize: expands an assembled instruction into canonical 64-bit form
package de_isa_def;

    localparam logic [1:0] LEN_16 = 2'd0;
    localparam logic [1:0] LEN_32 = 2'd1;
    localparam logic [1:0] LEN_64 = 2'd2;

    // Native opcodes; bit 5 set marks the I-type group.
    localparam logic [5:0] OP_ADD     = 6'h01;
    localparam logic [5:0] OP_SUB     = 6'h02;
    localparam logic [5:0] OP_SYSCALL = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h21;
    localparam logic [5:0] OP_SUBI    = 6'h22;
    localparam logic [5:0] OP_SLTI    = 6'h2A;
    localparam logic [5:0] OP_SGTI    = 6'h2B;
    localparam logic [5:0] OP_J       = 6'h30;
    localparam logic [5:0] OP_JAL     = 6'h31;

    localparam logic [2:0] OP16_ADD     = 3'd0;
    localparam logic [2:0] OP16_SUB     = 3'd1;
    localparam logic [2:0] OP16_ADDI    = 3'd2;
    localparam logic [2:0] OP16_SUBI    = 3'd3;
    localparam logic [2:0] OP16_SYSCALL = 3'd4;
    localparam logic [2:0] OP16_J       = 3'd5;
    localparam logic [2:0] OP16_JAL     = 3'd6;

    function automatic logic [1:0] len_of(input logic [15:0] head);
        logic [1:0] len;
        if (!head[15])      len = LEN_16;
        else if (!head[14]) len = LEN_32;
        else                len = LEN_64;
        return len;
    endfunction

    function automatic logic [2:0] parcels_of(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_16:  n = 3'd1;
            LEN_32:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] op16_map(input logic [2:0] code);
        logic [5:0] op;
        case (code)
            OP16_ADD:     op = OP_ADD;
            OP16_SUB:     op = OP_SUB;
            OP16_ADDI:    op = OP_ADDI;
            OP16_SUBI:    op = OP_SUBI;
            OP16_SYSCALL: op = OP_SYSCALL;
            OP16_J:       op = OP_J;
            OP16_JAL:     op = OP_JAL;
            default:      op = 6'd0;
        endcase
        return op;
    endfunction

    // inst holds the head parcel in [63:48]; bits beyond the instruction length are ignored.
    function automatic logic [63:0] canonicalize(input logic [63:0] inst, input logic [1:0] len);
        logic [63:0] o;
        logic [5:0]  op;
        logic        sext;
        o    = inst;
        op   = inst[61:56];
        sext = 1'b0;
        case (len)
            LEN_16: begin
                o = {2'b11, op16_map(inst[62:60]), inst[59:54], 6'd0, inst[59:54],
                     inst[53:48], {{26{inst[53]}}, inst[53:48]}};
            end
            LEN_32: begin
                if (inst[61]) begin
                    // Compare ops need a signed immediate even in the otherwise-unsigned group.
                    sext = inst[60] || (inst[60:58] == 3'b000) || (op == OP_SLTI) || (op == OP_SGTI);
                    o = {2'b11, inst[61:50], 6'd0, inst[49:44], 6'd0,
                         sext ? {{20{inst[43]}}, inst[43:32]} : {20'd0, inst[43:32]}};
                end else begin
                    o = {2'b11, inst[61:32], 32'd0};
                end
            end
            default: o = inst;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/de_parcel_queue.sv
// de_parcel_queue: circular buffer of 16-bit parcels.
//   push_i/push_data_i/push_off_i : writes parcels push_off_i..3 at the write pointer
//   pop_i/pop_cnt_i               : retires pop_cnt_i parcels at the read pointer
//   flush_i                       : empties the queue (wins over push/pop)
//   count_o                       : parcels held
//   win_o                         : four parcels starting at the read pointer, head in [63:48]
module de_parcel_queue #(
    parameter int BUF_PARCELS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [63:0]                    push_data_i,
    input  logic [1:0]                     push_off_i,
    input  logic                           pop_i,
    input  logic [2:0]                     pop_cnt_i,
    output logic [$clog2(BUF_PARCELS):0]   count_o,
    output logic [63:0]                    win_o
);

    localparam int PTR_W = $clog2(BUF_PARCELS);
    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      mem_q [BUF_PARCELS];
    logic [15:0]      mem_d [BUF_PARCELS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_idx;
    logic [2:0]       push_cnt;

    assign push_cnt = 3'd4 - {1'b0, push_off_i};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_idx   = '0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= int'(push_off_i)) begin
                        wr_idx        = wr_ptr_q + PTR_W'(i - int'(push_off_i));
                        mem_d[wr_idx] = push_data_i[63-16*i -: 16];
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
                count_d  = count_d + CNT_W'(push_cnt);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt_i);
                count_d  = count_d - CNT_W'(pop_cnt_i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BUF_PARCELS; k++) mem_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointer arithmetic wraps naturally since the depth is a power of two.
    always_comb begin
        win_o = '0;
        for (int j = 0; j < 4; j++) begin
            win_o[63-16*j -: 16] = mem_q[rd_ptr_q + PTR_W'(j)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/de_align_expand.sv
// de_align_expand: instruction aligner/expander between fetch and decode.
//   fetch_valid_i/fetch_ready_o/fetch_data_i/fetch_off_i : 64-bit fetch words of four parcels
//   inst_valid_o/inst_ready_i/inst_data_o/inst_len_o     : one canonical instruction per cycle
//   flush_i                                               : discards all buffered parcels
// Optional macro DE_ALIGN_PC_TRACK_EN adds flush_pc_i / inst_pc_o head-PC tracking.
module de_align_expand
    import de_isa_def::*;
#(
    parameter int BUF_PARCELS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [63:0] fetch_data_i,
    input  logic [1:0]  fetch_off_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [63:0] inst_data_o,
    output logic [1:0]  inst_len_o
`ifdef DE_ALIGN_PC_TRACK_EN
    ,
    input  logic [63:0] flush_pc_i,
    output logic [63:0] inst_pc_o
`endif
);

    localparam int PTR_W = $clog2(BUF_PARCELS);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count;
    logic [63:0]      win;
    logic [1:0]       len;
    logic [2:0]       need;
    logic             push;
    logic             pop;

    assign len  = len_of(win[63:48]);
    assign need = parcels_of(len);

    // Ready looks only at the registered count, keeping inst_ready_i off this path.
    assign fetch_ready_o = (count <= CNT_W'(BUF_PARCELS - 4)) && !flush_i;
    assign inst_valid_o  = (count >= CNT_W'(need)) && !flush_i;
    assign push          = fetch_valid_i && fetch_ready_o;
    assign pop           = inst_valid_o && inst_ready_i;
    assign inst_data_o   = inst_valid_o ? canonicalize(win, len) : 64'd0;
    assign inst_len_o    = inst_valid_o ? len : 2'd0;

    de_parcel_queue #(
        .BUF_PARCELS (BUF_PARCELS)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (fetch_data_i),
        .push_off_i  (fetch_off_i),
        .pop_i       (pop),
        .pop_cnt_i   (need),
        .count_o     (count),
        .win_o       (win)
    );

`ifdef DE_ALIGN_PC_TRACK_EN
    logic [63:0] pc_q, pc_d;
    logic        pc_skip_q, pc_skip_d;

    // The first push after a redirect may start mid-word; its dropped parcels still occupy address space.
    always_comb begin
        pc_d      = pc_q;
        pc_skip_d = pc_skip_q;
        if (flush_i) begin
            pc_d      = flush_pc_i;
            pc_skip_d = 1'b1;
        end else begin
            if (pop) pc_d = pc_d + {60'd0, need, 1'b0};
            if (push && pc_skip_q) begin
                pc_d      = pc_d + {61'd0, fetch_off_i, 1'b0};
                pc_skip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            pc_skip_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pc_skip_q <= pc_skip_d;
        end
    end

    assign inst_pc_o = inst_valid_o ? pc_q : 64'd0;
`endif

endmodule

// File: tb/tb_de_align_expand.sv
module tb_de_align_expand;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [63:0] fetch_data_i;
    logic [1:0]  fetch_off_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [63:0] inst_data_o;
    logic [1:0]  inst_len_o;
`ifdef DE_ALIGN_PC_TRACK_EN
    logic [63:0] flush_pc_i;
    logic [63:0] inst_pc_o;
`endif

    de_align_expand #(.BUF_PARCELS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_data_i  (fetch_data_i),
        .fetch_off_i   (fetch_off_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_data_o   (inst_data_o),
        .inst_len_o    (inst_len_o)
`ifdef DE_ALIGN_PC_TRACK_EN
        ,
        .flush_pc_i    (flush_pc_i),
        .inst_pc_o     (inst_pc_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mq[$];
    logic [63:0] m_pc    = 64'd0;
    bit          m_skip  = 1'b0;
    logic [63:0] pc_load = 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int need_of(input logic [15:0] h);
        if (!h[15]) return 1;
        if (!h[14]) return 2;
        return 4;
    endfunction

    function automatic logic [5:0] native16(input logic [2:0] c);
        case (c)
            3'd0: return 6'h01;
            3'd1: return 6'h02;
            3'd2: return 6'h21;
            3'd3: return 6'h22;
            3'd4: return 6'h03;
            3'd5: return 6'h30;
            3'd6: return 6'h31;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [63:0] ref_expand(input logic [63:0] raw, input int n);
        logic [63:0] r;
        logic [5:0]  op;
        logic [31:0] imm;
        bit          sx;
        r = raw;
        if (n == 1) begin
            imm = {26'd0, raw[53:48]};
            if (raw[53]) imm = imm - 32'd64;
            r = {2'b11, native16(raw[62:60]), raw[59:54], 6'd0, raw[59:54], raw[53:48], imm};
        end else if (n == 2) begin
            op = raw[61:56];
            if (op[5]) begin
                sx  = op[4] || (op[4:2] == 3'd0) || (op == 6'h2A) || (op == 6'h2B);
                imm = {20'd0, raw[43:32]};
                if (sx && raw[43]) imm = imm - 32'd4096;
                r = {2'b11, raw[61:50], 6'd0, raw[49:44], 6'd0, imm};
            end else begin
                r = {2'b11, raw[61:32], 32'd0};
            end
        end
        return r;
    endfunction

    // One clock: drive inputs, compare against the parcel-queue model, then advance the model.
    task automatic cyc(input bit fv, input logic [63:0] fd, input logic [1:0] fo,
                       input bit ir, input bit fl);
        int          n;
        bit          er, ev;
        logic [63:0] raw;
        fetch_valid_i = fv;
        fetch_data_i  = fd;
        fetch_off_i   = fo;
        inst_ready_i  = ir;
        flush_i       = fl;
`ifdef DE_ALIGN_PC_TRACK_EN
        flush_pc_i    = pc_load;
`endif
        #1;
        er  = (mq.size() <= 4) && !fl;
        n   = (mq.size() > 0) ? need_of(mq[0]) : 1;
        ev  = !fl && (mq.size() >= n);
        raw = 64'd0;
        if (ev) for (int k = 0; k < n; k++) raw[63-16*k -: 16] = mq[k];
        chk("fetch_ready", fetch_ready_o, er);
        chk("inst_valid", inst_valid_o, ev);
        chk("inst_data", inst_data_o, ev ? ref_expand(raw, n) : 64'd0);
        chk("inst_len", inst_len_o, ev ? ((n == 1) ? 64'd0 : (n == 2) ? 64'd1 : 64'd2) : 64'd0);
`ifdef DE_ALIGN_PC_TRACK_EN
        chk("inst_pc", inst_pc_o, ev ? m_pc : 64'd0);
`endif
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_pc   = pc_load;
            m_skip = 1'b1;
        end else begin
            if (ev && ir) begin
                repeat (n) void'(mq.pop_front());
                m_pc = m_pc + 64'(2 * n);
            end
            if (fv && er) begin
                for (int k = int'(fo); k < 4; k++) mq.push_back(fd[63-16*k -: 16]);
                if (m_skip) m_pc = m_pc + 64'(2 * int'(fo));
                m_skip = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) cyc(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_data_i  = 64'd0;
        fetch_off_i   = 2'd0;
        inst_ready_i  = 1'b0;
`ifdef DE_ALIGN_PC_TRACK_EN
        flush_pc_i    = 64'd0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", inst_valid_o, 64'd0);
        chk("rst_data", inst_data_o, 64'd0);
        chk("rst_len", inst_len_o, 64'd0);
        chk("rst_ready", fetch_ready_o, 64'd1);
        rst_n = 1'b1;

        // Four compressed SUB instructions from one word.
        cyc(1'b1, 64'h1234_1234_1234_1234, 2'd0, 1'b1, 1'b0);
        #1;
        chk("c16_first", inst_data_o, 64'hC220_0234_FFFF_FFF4);
        idle(5);

        // 64-bit instruction straddling two fetch words.
        cyc(1'b1, 64'h0000_8000_0000_C000, 2'd1, 1'b1, 1'b0);
        cyc(1'b0, 64'd0, 2'd0, 1'b1, 1'b0);
        #1;
        chk("straddle_wait", inst_valid_o, 64'd0);
        cyc(1'b1, 64'd0, 2'd0, 1'b1, 1'b0);
        #1;
        chk("straddle_data", inst_data_o, 64'hC000_0000_0000_0000);
        chk("straddle_len", inst_len_o, 64'd2);
        idle(4);

        // Back-pressure until full, then drain in order.
        for (int w = 0; w < 3; w++) cyc(1'b1, 64'h1234_1234_1234_1234 + 64'(w), 2'd0, 1'b0, 1'b0);
        #1;
        chk("full_ready", fetch_ready_o, 64'd0);
        idle(10);

        // Flush drops a partial 32-bit instruction.
        cyc(1'b1, 64'h1234_1234_1234_8001, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 64'd0, 2'd0, 1'b1, 1'b1);
        #1;
        chk("post_flush_valid", inst_valid_o, 64'd0);
        cyc(1'b1, 64'hAAAA_1111_2222_3333, 2'd2, 1'b1, 1'b0);
        #1;
        chk("post_flush_data", inst_data_o, 64'hE120_0222_FFFF_FFE2);
        idle(4);

`ifdef DE_ALIGN_PC_TRACK_EN
        pc_load = 64'h1000;
        cyc(1'b0, 64'd0, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 64'h0000_1234_1234_1234, 2'd1, 1'b0, 1'b0);
        #1;
        chk("pc_first", inst_pc_o, 64'h1002);
        idle(4);
`endif

        // Randomized mix across many pointer wraps.
        for (int c = 0; c < 3000; c++) begin
            pc_load = {$urandom(), $urandom()} & ~64'd1;
            cyc($urandom_range(0, 99) < 70, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
        end

        // Asynchronous reset in the middle of traffic.
        cyc(1'b1, 64'h1234_8000_0000_1234, 2'd0, 1'b0, 1'b0);
        fetch_valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", inst_valid_o, 64'd0);
        chk("mid_rst_ready", fetch_ready_o, 64'd1);
        chk("mid_rst_data", inst_data_o, 64'd0);
        mq.delete();
        m_pc   = 64'd0;
        m_skip = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 64'hC000_1111_2222_3333, 2'd0, 1'b1, 1'b0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
